memory_arbiter_rv32: RTL and testbench

Shares the single RV32 memory port between the instruction-fetch path and the load/store path of the core. It sits between the fetch/execute stages and the memory model. Fetch and data requesters each see a private request/ready handshake. The block sequences one memory transaction at a time with round-robin arbitration and a watchdog timeout.

---
 rtl/rv32_memory_pkg.sv | 26 ++
 rtl/memory_arbiter_rv32.sv | 163 ++++++++++++++++
 tb/tb_memory_arbiter_rv32.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32_memory_pkg.sv
// Shared types and helpers for the RV32 memory-port arbiter.
package rv32_memory_pkg;

    typedef enum logic {
        StIdle,
        StAccess
    } state_e;

    typedef enum logic {
        GrantFetch,
        GrantData
    } grant_e;

    localparam logic [3:0] BYTE_ENABLE_ALL = 4'hF;

    // A tie goes to whichever requester was not served last.
    function automatic grant_e pick_grant(input logic   fetch_req,
                                          input logic   data_req,
                                          input grant_e last_grant);
        if (fetch_req && data_req) begin
            return (last_grant == GrantFetch) ? GrantData : GrantFetch;
        end
        return data_req ? GrantData : GrantFetch;
    endfunction

endpackage

// File: rtl/memory_arbiter_rv32.sv
// Shares the single RV32 memory port between instruction fetch and load/store.
// One transaction in flight at a time, round-robin on ties, watchdog abort.
module memory_arbiter_rv32
    import rv32_memory_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                     i_clock,
    input  logic                     i_reset_n,
    input  logic                     i_enable,

    input  logic                     i_fetch_request,
    input  logic [ADDRESS_WIDTH-1:0] i_fetch_address,
    output logic                     o_fetch_ready,
    output logic [DATA_WIDTH-1:0]    o_fetch_data,
    output logic                     o_fetch_error,

    input  logic                     i_data_request,
    input  logic                     i_data_write,
    input  logic [ADDRESS_WIDTH-1:0] i_data_address,
    input  logic [DATA_WIDTH-1:0]    i_data_write_value,
    input  logic [3:0]               i_data_byte_enable,
    output logic                     o_data_ready,
    output logic [DATA_WIDTH-1:0]    o_data_read_value,
    output logic                     o_data_error,

    output logic                     o_memory_request,
    output logic                     o_memory_write,
    output logic [ADDRESS_WIDTH-1:0] o_memory_address,
    output logic [DATA_WIDTH-1:0]    o_memory_write_value,
    output logic [3:0]               o_memory_byte_enable,
    input  logic                     i_memory_ready,
    input  logic [DATA_WIDTH-1:0]    i_memory_read_value
);

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    state_e                   r_state;
    grant_e                   r_last_grant;
    grant_e                   r_grant;
    logic [7:0]               r_counter;

    logic                     r_memory_request;
    logic                     r_memory_write;
    logic [ADDRESS_WIDTH-1:0] r_memory_address;
    logic [DATA_WIDTH-1:0]    r_memory_write_value;
    logic [3:0]               r_memory_byte_enable;

    logic                     r_fetch_ready;
    logic [DATA_WIDTH-1:0]    r_fetch_data;
    logic                     r_fetch_error;
    logic                     r_data_ready;
    logic [DATA_WIDTH-1:0]    r_data_read_value;
    logic                     r_data_error;

    logic                     w_fetch_eligible;
    logic                     w_data_eligible;
    logic                     w_grant_valid;
    grant_e                   w_grant_pick;
    logic                     w_timeout;
    logic                     w_finish;

    // A requester whose completion pulse is high this cycle is still holding
    // the old request; treat it as absent so it is not served twice.
    assign w_fetch_eligible = i_fetch_request & ~r_fetch_ready;
    assign w_data_eligible  = i_data_request & ~r_data_ready;
    assign w_grant_valid    = i_enable & (w_fetch_eligible | w_data_eligible);
    assign w_grant_pick     = pick_grant(w_fetch_eligible, w_data_eligible, r_last_grant);
    assign w_timeout        = (r_counter == TIMEOUT_LIMIT);
    assign w_finish         = i_memory_ready | w_timeout;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state              <= StIdle;
            r_last_grant         <= GrantFetch;
            r_grant              <= GrantFetch;
            r_counter            <= '0;
            r_memory_request     <= 1'b0;
            r_memory_write       <= 1'b0;
            r_memory_address     <= '0;
            r_memory_write_value <= '0;
            r_memory_byte_enable <= '0;
            r_fetch_ready        <= 1'b0;
            r_fetch_data         <= '0;
            r_fetch_error        <= 1'b0;
            r_data_ready         <= 1'b0;
            r_data_read_value    <= '0;
            r_data_error         <= 1'b0;
        end else begin
            r_fetch_ready <= 1'b0;
            r_fetch_error <= 1'b0;
            r_data_ready  <= 1'b0;
            r_data_error  <= 1'b0;

            case (r_state)
                StIdle: begin
                    if (w_grant_valid) begin
                        r_state          <= StAccess;
                        r_grant          <= w_grant_pick;
                        r_last_grant     <= w_grant_pick;
                        r_counter        <= '0;
                        r_memory_request <= 1'b1;
                        if (w_grant_pick == GrantData) begin
                            r_memory_write       <= i_data_write;
                            r_memory_address     <= i_data_address;
                            r_memory_write_value <= i_data_write_value;
                            r_memory_byte_enable <= i_data_write ? i_data_byte_enable
                                                                 : BYTE_ENABLE_ALL;
                        end else begin
                            r_memory_write       <= 1'b0;
                            r_memory_address     <= i_fetch_address;
                            r_memory_write_value <= '0;
                            r_memory_byte_enable <= BYTE_ENABLE_ALL;
                        end
                    end
                end

                StAccess: begin
                    if (w_finish) begin
                        // memory_ready wins over a coincident timeout.
                        r_state          <= StIdle;
                        r_memory_request <= 1'b0;
                        if (r_grant == GrantFetch) begin
                            r_fetch_ready <= 1'b1;
                            r_fetch_error <= ~i_memory_ready;
                            if (i_memory_ready) begin
                                r_fetch_data <= i_memory_read_value;
                            end
                        end else begin
                            r_data_ready <= 1'b1;
                            r_data_error <= ~i_memory_ready;
                            if (i_memory_ready && !r_memory_write) begin
                                r_data_read_value <= i_memory_read_value;
                            end
                        end
                    end else begin
                        r_counter <= r_counter + 8'd1;
                    end
                end

                default: begin
                    r_state          <= StIdle;
                    r_memory_request <= 1'b0;
                end
            endcase
        end
    end

    assign o_memory_request     = r_memory_request;
    assign o_memory_write       = r_memory_write;
    assign o_memory_address     = r_memory_address;
    assign o_memory_write_value = r_memory_write_value;
    assign o_memory_byte_enable = r_memory_byte_enable;
    assign o_fetch_ready        = r_fetch_ready;
    assign o_fetch_data         = r_fetch_data;
    assign o_fetch_error        = r_fetch_error;
    assign o_data_ready         = r_data_ready;
    assign o_data_read_value    = r_data_read_value;
    assign o_data_error         = r_data_error;

endmodule

// File: tb/tb_memory_arbiter_rv32.sv
// Self-checking bench for memory_arbiter_rv32: directed scenarios, then
// randomized traffic against a transaction-level reference model.
module tb_memory_arbiter_rv32;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        fetch_request;
    logic [31:0] fetch_address;
    logic        fetch_ready;
    logic [31:0] fetch_data;
    logic        fetch_error;
    logic        data_request;
    logic        data_write;
    logic [31:0] data_address;
    logic [31:0] data_write_value;
    logic [3:0]  data_byte_enable;
    logic        data_ready;
    logic [31:0] data_read_value;
    logic        data_error;
    logic        memory_request;
    logic        memory_write;
    logic [31:0] memory_address;
    logic [31:0] memory_write_value;
    logic [3:0]  memory_byte_enable;
    logic        memory_ready;
    logic [31:0] memory_read_value;

    always #5 clk = ~clk;

    memory_arbiter_rv32 #(
        .ADDRESS_WIDTH (32),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_clock             (clk),
        .i_reset_n           (rst_n),
        .i_enable            (enable),
        .i_fetch_request     (fetch_request),
        .i_fetch_address     (fetch_address),
        .o_fetch_ready       (fetch_ready),
        .o_fetch_data        (fetch_data),
        .o_fetch_error       (fetch_error),
        .i_data_request      (data_request),
        .i_data_write        (data_write),
        .i_data_address      (data_address),
        .i_data_write_value  (data_write_value),
        .i_data_byte_enable  (data_byte_enable),
        .o_data_ready        (data_ready),
        .o_data_read_value   (data_read_value),
        .o_data_error        (data_error),
        .o_memory_request    (memory_request),
        .o_memory_write      (memory_write),
        .o_memory_address    (memory_address),
        .o_memory_write_value(memory_write_value),
        .o_memory_byte_enable(memory_byte_enable),
        .i_memory_ready      (memory_ready),
        .i_memory_read_value (memory_read_value)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        enable            = 1'b1;
        fetch_request     = 1'b0;
        fetch_address     = '0;
        data_request      = 1'b0;
        data_write        = 1'b0;
        data_address      = '0;
        data_write_value  = '0;
        data_byte_enable  = '0;
        memory_ready      = 1'b0;
        memory_read_value = '0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, ".mreq"}, 32'(memory_request), 0);
        check({tag, ".mwr"}, 32'(memory_write), 0);
        check({tag, ".maddr"}, memory_address, 0);
        check({tag, ".mwval"}, memory_write_value, 0);
        check({tag, ".mbe"}, 32'(memory_byte_enable), 0);
        check({tag, ".frdy"}, 32'(fetch_ready), 0);
        check({tag, ".fdata"}, fetch_data, 0);
        check({tag, ".ferr"}, 32'(fetch_error), 0);
        check({tag, ".drdy"}, 32'(data_ready), 0);
        check({tag, ".drv"}, data_read_value, 0);
        check({tag, ".derr"}, 32'(data_error), 0);
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Zero-wait fetch/load whose request is already being driven.
    task automatic run_txn(input string tag, input logic is_data,
                           input logic [31:0] addr, input logic [31:0] rv);
        memory_ready      = 1'b1;
        memory_read_value = rv;
        @(negedge clk);
        check({tag, ".req"}, 32'(memory_request), 1);
        check({tag, ".addr"}, memory_address, addr);
        check({tag, ".be"}, 32'(memory_byte_enable), 32'hF);
        check({tag, ".wr"}, 32'(memory_write), 0);
        @(negedge clk);
        check({tag, ".reqdrop"}, 32'(memory_request), 0);
        if (is_data) begin
            check({tag, ".drdy"}, 32'(data_ready), 1);
            check({tag, ".derr"}, 32'(data_error), 0);
            check({tag, ".drv"}, data_read_value, rv);
            check({tag, ".frdy"}, 32'(fetch_ready), 0);
            data_request = 1'b0;
        end else begin
            check({tag, ".frdy"}, 32'(fetch_ready), 1);
            check({tag, ".ferr"}, 32'(fetch_error), 0);
            check({tag, ".fdata"}, fetch_data, rv);
            check({tag, ".drdy"}, 32'(data_ready), 0);
            fetch_request = 1'b0;
        end
        memory_ready = 1'b0;
    endtask

    // Reference model state for the random phase.
    logic        m_last_data;
    logic [31:0] m_fdata;
    logic [31:0] m_drv;
    logic        exp_grant_pending;
    logic        exp_grant_data;
    logic        active;
    logic        t_is_data;
    logic        t_write;
    logic [31:0] t_addr;
    logic [31:0] t_wval;
    logic [3:0]  t_be;
    logic [31:0] t_rv;
    int          t_k;
    int          t_lat;
    int          t_exp;
    logic        done_f;
    logic        done_d;
    logic        ef;
    logic        ed;

    task automatic new_fetch();
        fetch_request = 1'b1;
        fetch_address = $urandom;
    endtask

    task automatic new_data();
        data_request     = 1'b1;
        data_write       = ($urandom_range(0, 1) == 1);
        data_address     = $urandom;
        data_write_value = $urandom;
        data_byte_enable = 4'($urandom);
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Fetch only, zero-wait memory.
        fetch_request = 1'b1;
        fetch_address = 32'h0000_0010;
        run_txn("fetch1", 1'b0, 32'h0000_0010, 32'h0000_0093);
        @(negedge clk);
        check("fetch1.pulse", 32'(fetch_ready), 0);
        check("fetch1.idle", 32'(memory_request), 0);

        // Ties: first after reset goes to DATA, then alternation by last grant.
        do_reset();
        fetch_request = 1'b1; fetch_address = 32'h200;
        data_request  = 1'b1; data_write = 1'b0; data_address = 32'h300;
        run_txn("tie1d", 1'b1, 32'h300, 32'h1111_0000);
        run_txn("tie1f", 1'b0, 32'h200, 32'h2222_0000);
        @(negedge clk);
        fetch_request = 1'b1; fetch_address = 32'h204;
        data_request  = 1'b1; data_address  = 32'h304;
        run_txn("tie2d", 1'b1, 32'h304, 32'h0000_3333);
        run_txn("tie2f", 1'b0, 32'h204, 32'h0000_4444);
        data_request = 1'b1; data_address = 32'h308;
        run_txn("donly", 1'b1, 32'h308, 32'h0000_5555);
        @(negedge clk);
        fetch_request = 1'b1; fetch_address = 32'h20C;
        data_request  = 1'b1; data_address  = 32'h30C;
        run_txn("tie3f", 1'b0, 32'h20C, 32'h0000_6666);
        run_txn("tie3d", 1'b1, 32'h30C, 32'h0000_7777);

        // Store with three wait cycles.
        @(negedge clk);
        data_request = 1'b1; data_write = 1'b1; data_address = 32'h100;
        data_write_value = 32'hDEAD_BEEF; data_byte_enable = 4'b0011;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("store.req", 32'(memory_request), 1);
            check("store.addr", memory_address, 32'h100);
            check("store.wr", 32'(memory_write), 1);
            check("store.wval", memory_write_value, 32'hDEAD_BEEF);
            check("store.be", 32'(memory_byte_enable), 32'h3);
            check("store.early", 32'(data_ready), 0);
            if (k == 3) begin
                memory_ready      = 1'b1;
                memory_read_value = 32'hBAD0_BAD0;
            end
        end
        @(negedge clk);
        check("store.drdy", 32'(data_ready), 1);
        check("store.derr", 32'(data_error), 0);
        check("store.drv", data_read_value, 32'h0000_7777);
        check("store.reqdrop", 32'(memory_request), 0);
        data_request = 1'b0; data_write = 1'b0; memory_ready = 1'b0;

        // Timeout: memory never answers.
        @(negedge clk);
        data_request = 1'b1; data_address = 32'h44;
        for (int k = 0; k <= int'(TO); k++) begin
            @(negedge clk);
            check("tmo.req", 32'(memory_request), 1);
            check("tmo.early", 32'(data_ready), 0);
        end
        @(negedge clk);
        check("tmo.drdy", 32'(data_ready), 1);
        check("tmo.derr", 32'(data_error), 1);
        check("tmo.drv", data_read_value, 32'h0000_7777);
        check("tmo.reqdrop", 32'(memory_request), 0);
        data_request = 1'b0;
        @(negedge clk);
        check("tmo.pulse", 32'(data_ready), 0);
        check("tmo.idle", 32'(memory_request), 0);

        // Fetch request held one cycle past fetch_ready.
        fetch_request = 1'b1; fetch_address = 32'h80;
        memory_ready = 1'b1; memory_read_value = 32'h13;
        @(negedge clk);
        check("hold.g1", 32'(memory_request), 1);
        @(negedge clk);
        check("hold.r1", 32'(fetch_ready), 1);
        @(negedge clk);
        check("hold.mask", 32'(memory_request), 0);
        check("hold.pulse", 32'(fetch_ready), 0);
        @(negedge clk);
        check("hold.g2", 32'(memory_request), 1);
        @(negedge clk);
        check("hold.r2", 32'(fetch_ready), 1);
        fetch_request = 1'b0;
        @(negedge clk);
        check("hold.end", 32'(memory_request), 0);
        check("hold.endpulse", 32'(fetch_ready), 0);
        memory_ready = 1'b0;

        // enable=0 blocks new grants but not an in-flight one.
        enable = 1'b0;
        fetch_request = 1'b1; fetch_address = 32'h90;
        repeat (3) begin
            @(negedge clk);
            check("en.blocked", 32'(memory_request), 0);
        end
        enable = 1'b1;
        @(negedge clk);
        check("en.grant", 32'(memory_request), 1);
        enable = 1'b0;
        memory_ready = 1'b1; memory_read_value = 32'h55AA_55AA;
        @(negedge clk);
        check("en.frdy", 32'(fetch_ready), 1);
        check("en.fdata", fetch_data, 32'h55AA_55AA);
        fetch_request = 1'b0; memory_ready = 1'b0; enable = 1'b1;

        // Reset in the middle of an access.
        @(negedge clk);
        data_request = 1'b1; data_write = 1'b0; data_address = 32'hA0;
        @(negedge clk);
        check("rstmid.req", 32'(memory_request), 1);
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("rstmid");
        data_request = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (TO + 3) begin
            @(negedge clk);
            check("rstmid.noreport", 32'(data_ready), 0);
            check("rstmid.idle", 32'(memory_request), 0);
        end

        // Randomized traffic against the transaction-level model.
        do_reset();
        m_last_data = 1'b0;
        m_fdata = '0;
        m_drv = '0;
        exp_grant_pending = 1'b0;
        exp_grant_data = 1'b0;
        active = 1'b0;
        t_k = 0; t_lat = 0; t_exp = 0;
        t_is_data = 1'b0; t_write = 1'b0; t_addr = '0; t_wval = '0; t_be = '0; t_rv = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            done_f = 1'b0;
            done_d = 1'b0;
            if (exp_grant_pending) begin
                exp_grant_pending = 1'b0;
                active = 1'b1;
                t_k    = 0;
                t_lat  = $urandom_range(0, TO + 2);
                t_exp  = (t_lat <= int'(TO)) ? t_lat + 1 : int'(TO) + 1;
                t_rv   = $urandom;
            end
            if (active) begin
                if (t_k == t_exp) begin
                    check("rnd.reqdrop", 32'(memory_request), 0);
                    if (!t_is_data) begin
                        if (t_lat <= int'(TO)) m_fdata = t_rv;
                        check("rnd.frdy", 32'(fetch_ready), 1);
                        check("rnd.ferr", 32'(fetch_error), 32'(t_lat > int'(TO)));
                        check("rnd.fdata", fetch_data, m_fdata);
                        check("rnd.drdy0", 32'(data_ready), 0);
                        done_f = 1'b1;
                    end else begin
                        if (t_lat <= int'(TO) && !t_write) m_drv = t_rv;
                        check("rnd.drdy", 32'(data_ready), 1);
                        check("rnd.derr", 32'(data_error), 32'(t_lat > int'(TO)));
                        check("rnd.drv", data_read_value, m_drv);
                        check("rnd.frdy0", 32'(fetch_ready), 0);
                        done_d = 1'b1;
                    end
                    active = 1'b0;
                end else begin
                    check("rnd.req", 32'(memory_request), 1);
                    check("rnd.addr", memory_address, t_addr);
                    check("rnd.wr", 32'(memory_write), 32'(t_write));
                    check("rnd.be", 32'(memory_byte_enable), 32'(t_be));
                    if (t_write) check("rnd.wval", memory_write_value, t_wval);
                    check("rnd.noready", 32'({fetch_ready, data_ready}), 0);
                end
            end else begin
                check("rnd.idle", 32'(memory_request), 0);
                check("rnd.idleready", 32'({fetch_ready, data_ready}), 0);
            end

            if (active) begin
                memory_ready      = (t_k == t_lat);
                memory_read_value = (t_k == t_lat) ? t_rv : $urandom;
                t_k++;
            end else begin
                memory_ready      = ($urandom_range(0, 3) == 0);
                memory_read_value = $urandom;
            end

            if (done_f) begin
                if ($urandom_range(0, 3) == 0) new_fetch();
                else fetch_request = 1'b0;
            end else if (!fetch_request && $urandom_range(0, 1) == 1) begin
                new_fetch();
            end
            if (done_d) begin
                if ($urandom_range(0, 3) == 0) new_data();
                else data_request = 1'b0;
            end else if (!data_request && $urandom_range(0, 1) == 1) begin
                new_data();
            end
            enable = ($urandom_range(0, 7) != 0);

            // A completing requester is still shown its ready pulse at the next edge.
            if (!active) begin
                ef = fetch_request && !done_f;
                ed = data_request && !done_d;
                if (enable && (ef || ed)) begin
                    exp_grant_pending = 1'b1;
                    exp_grant_data    = ed && (!ef || !m_last_data);
                    m_last_data       = exp_grant_data;
                    t_is_data         = exp_grant_data;
                    if (exp_grant_data) begin
                        t_addr  = data_address;
                        t_write = data_write;
                        t_wval  = data_write_value;
                        t_be    = data_write ? data_byte_enable : 4'hF;
                    end else begin
                        t_addr  = fetch_address;
                        t_write = 1'b0;
                        t_wval  = '0;
                        t_be    = 4'hF;
                    end
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
